// File: rtl/run_ctrl.sv
// CPU run controller: divides clk into one-cycle cpu_en pulses, with free-run, single-step, halt and resume.
// Latency: go press acts 3 clk edges after go rises; cpu_en/state are registered (one cycle after the deciding edge).
// Backpressure: none; halt is sampled every cycle and always wins over go and the terminal count.
module run_ctrl #(
  parameter int DIV0 = 10000,
  parameter int DIV1 = 100000,
  parameter int DIV2 = 1000000,
  parameter int DIV3 = 10000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  hz,
  input  logic        go,
  input  logic        step_mode,
  input  logic        halt,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);

  // Divider counter must hold the largest terminal value (every DIVn is at least 2).
  localparam int DMAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int DMAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int DMAX   = (DMAX01 > DMAX23) ? DMAX01 : DMAX23;
  localparam int CW     = $clog2(DMAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10,
    S_RESUME = 2'b11
  } state_t;

  logic          r_go_s1;
  logic          r_go_s2;
  logic          r_go_d;
  logic [1:0]    r_vld;
  logic          r_armed;
  logic [1:0]    r_hz;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic          r_cpu_en;
  logic [31:0]   r_cycle_cnt;

  logic          w_go_pulse;
  logic          w_hz_chg;
  logic [CW-1:0] w_last;

  // Go synchronizer, edge flop and arming; r_armed stays low until go has really been sampled low,
  // so a button held through reset cannot fire once reset releases.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_go_s1 <= 1'b0;
      r_go_s2 <= 1'b0;
      r_go_d  <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_go_s1 <= go;
      r_go_s2 <= r_go_s1;
      r_go_d  <= r_go_s2;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~r_go_s2);
    end
  end

  assign w_go_pulse = r_go_s2 & ~r_go_d & r_armed;

  // Speed select register; the divider restarts on the edge that loads a new value.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_hz <= 2'b00;
    end else begin
      r_hz <= hz;
    end
  end

  assign w_hz_chg = (hz != r_hz);

  // Terminal divider value for the currently registered speed.
  always_comb begin
    w_last = CW'(DIV0 - 1);
    case (r_hz)
      2'b00:   w_last = CW'(DIV0 - 1);
      2'b01:   w_last = CW'(DIV1 - 1);
      2'b10:   w_last = CW'(DIV2 - 1);
      default: w_last = CW'(DIV3 - 1);
    endcase
  end

  // Run/halt FSM with divider, registered cpu_en and pulse counter; priority in RUN is halt, go, hz change, count.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cpu_en    <= 1'b0;
      r_cycle_cnt <= 32'd0;
    end else begin
      r_cpu_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_go_pulse) begin
            if (step_mode) begin
              r_cpu_en    <= 1'b1;
              r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state <= S_HALTED;
            r_cnt   <= '0;
          end else if (w_go_pulse) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_hz_chg) begin
            r_cnt <= '0;
          end else if (r_cnt >= w_last) begin
            r_cnt       <= '0;
            r_cpu_en    <= 1'b1;
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HALTED: begin
          r_cnt <= '0;
          if (w_go_pulse) begin
            r_state     <= S_RESUME;
            r_cpu_en    <= 1'b1;
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= step_mode ? S_IDLE : S_RUN;
        end
      endcase
    end
  end

  assign cpu_en    = r_cpu_en;
  assign state     = r_state;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl with DIV0..DIV3 = 4, 6, 8, 10.
// A deadline-based model predicts state, cpu_en and cycle_cnt every cycle; directed steps add literal checks.
// Inputs change 1 ns (or 3 ns for clr/force) after a rising edge; all checks sample 1 ns after a rising edge.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [1:0]  hz = 2'b00;
  logic        go = 1'b0;
  logic        step_mode = 1'b0;
  logic        halt = 1'b0;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  run_ctrl #(.DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10)) dut (
    .clk       (clk),
    .clr       (clr),
    .hz        (hz),
    .go        (go),
    .step_mode (step_mode),
    .halt      (halt),
    .cpu_en    (cpu_en),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int period(input logic [1:0] s);
    case (s)
      2'b00:   return 4;
      2'b01:   return 6;
      2'b10:   return 8;
      default: return 10;
    endcase
  endfunction

  // Model: edges are numbered from reset release; a press is seen at edge k when go was sampled 0 at
  // edge k-3 and 1 at edge k-2 (k>=4). In RUN the next pulse is due at an absolute edge number.
  logic [1:0]  m_state;
  logic        m_en;
  logic [31:0] m_cnt;
  logic [1:0]  m_hz;
  logic        m_preload = 1'b0;
  logic        h1, h2, h3;
  int          k;
  int          dl;

  always @(posedge clk or negedge clr) begin : model
    logic gp;
    logic en_n;
    int   n;
    if (!clr) begin
      m_state = 2'd0;
      m_en    = 1'b0;
      m_cnt   = 32'd0;
      m_hz    = 2'd0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      k  = 0;
      dl = 0;
    end else begin
      k    = k + 1;
      gp   = (k >= 4) && h2 && !h3;
      n    = period(hz);
      en_n = 1'b0;
      if (m_preload) m_cnt = 32'hFFFF_FFFE;
      case (m_state)
        2'd0: begin
          if (gp) begin
            if (step_mode) en_n = 1'b1;
            else begin
              m_state = 2'd1;
              dl = k + n;
            end
          end
        end
        2'd1: begin
          if (halt) m_state = 2'd2;
          else if (gp) m_state = 2'd0;
          else if (hz != m_hz) dl = k + n;
          else if (k == dl) begin
            en_n = 1'b1;
            dl = k + n;
          end
        end
        2'd2: begin
          if (gp) begin
            m_state = 2'd3;
            en_n = 1'b1;
          end
        end
        default: begin
          m_state = step_mode ? 2'd0 : 2'd1;
          dl = k + n;
        end
      endcase
      m_en = en_n;
      if (en_n) m_cnt = m_cnt + 32'd1;
      m_hz = hz;
      h3 = h2;
      h2 = h1;
      h1 = go;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    check("cmp_state", 32'(state), 32'(m_state));
    check("cmp_en", 32'(cpu_en), 32'(m_en));
    check("cmp_cnt", cycle_cnt, m_cnt);
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] wrap_exp [3];
    wrap_exp[0] = 32'hFFFF_FFFF;
    wrap_exp[1] = 32'h0000_0000;
    wrap_exp[2] = 32'h0000_0001;

    // Reset values
    #2 clr = 1'b0;
    ticks(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_en", 32'(cpu_en), 32'd0);
    check("rst_cnt", cycle_cnt, 32'd0);
    #2 clr = 1'b1;
    ticks(4);

    // Free run at hz=00: RUN three edges after go rises, one pulse every 4 cycles
    go = 1'b1;
    ticks(2);
    check("pre_run_idle", 32'(state), 32'd0);
    tick();
    check("run_after_3", 32'(state), 32'd1);
    go = 1'b0;
    ticks(20);
    check("cnt_after_20", cycle_cnt, 32'd5);
    check("en_on_20th", 32'(cpu_en), 32'd1);

    // Speed change mid-count: divider restarts, next pulse 6 cycles after the change
    ticks(2);
    hz = 2'b01;
    tick();
    check("hzchg_no_en", 32'(cpu_en), 32'd0);
    ticks(5);
    check("hz_no_early", 32'(cpu_en), 32'd0);
    tick();
    check("hz_pulse_6", 32'(cpu_en), 32'd1);

    // Halt on the terminal-count cycle suppresses the pulse
    ticks(5);
    halt = 1'b1;
    tick();
    check("halt_tc_en", 32'(cpu_en), 32'd0);
    check("halt_tc_state", 32'(state), 32'd2);
    check("halt_tc_cnt", cycle_cnt, 32'd6);
    halt = 1'b0;
    ticks(2);
    check("halted_quiet", 32'(cpu_en), 32'd0);

    // Resume: one RESUME cycle with cpu_en, then RUN
    go = 1'b1;
    ticks(3);
    check("resume_state", 32'(state), 32'd3);
    check("resume_en", 32'(cpu_en), 32'd1);
    go = 1'b0;
    tick();
    check("resume_exit_run", 32'(state), 32'd1);
    check("resume_exit_en", 32'(cpu_en), 32'd0);
    check("resume_cnt", cycle_cnt, 32'd7);

    // go and halt together in RUN: halt wins
    ticks(3);
    go = 1'b1;
    ticks(2);
    halt = 1'b1;
    tick();
    check("go_halt_state", 32'(state), 32'd2);
    check("go_halt_en", 32'(cpu_en), 32'd0);
    go = 1'b0;
    halt = 1'b0;

    // Halt in the first RUN cycle after RESUME
    tick();
    go = 1'b1;
    ticks(3);
    check("resume2_state", 32'(state), 32'd3);
    go = 1'b0;
    tick();
    check("resume2_run", 32'(state), 32'd1);
    halt = 1'b1;
    tick();
    check("halt_first_run", 32'(state), 32'd2);
    halt = 1'b0;

    // Back to RUN, then step_mode flips while running: no effect until go
    tick();
    go = 1'b1;
    ticks(3);
    go = 1'b0;
    tick();
    step_mode = 1'b1;
    ticks(10);
    check("step_ignored_run", 32'(state), 32'd1);
    go = 1'b1;
    ticks(3);
    check("pause_idle", 32'(state), 32'd0);
    check("pause_en", 32'(cpu_en), 32'd0);
    go = 1'b0;

    // Reset mid-RUN with go held through release
    step_mode = 1'b0;
    tick();
    go = 1'b1;
    ticks(3);
    check("rerun", 32'(state), 32'd1);
    go = 1'b0;
    ticks(2);
    go = 1'b1;
    #2 clr = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_en", 32'(cpu_en), 32'd0);
    check("async_cnt", cycle_cnt, 32'd0);
    tick();
    #2 clr = 1'b1;
    ticks(10);
    check("no_restart", 32'(state), 32'd0);
    check("no_restart_cnt", cycle_cnt, 32'd0);
    go = 1'b0;
    ticks(3);

    // Single-step: three presses, three pulses, stays IDLE
    step_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      go = 1'b1;
      ticks(3);
      check("step_en", 32'(cpu_en), 32'd1);
      check("step_idle", 32'(state), 32'd0);
      go = 1'b0;
      tick();
      check("step_en_clear", 32'(cpu_en), 32'd0);
      ticks(2);
    end
    check("step_cnt3", cycle_cnt, 32'd3);

    // Counter wrap
    #2;
    force dut.r_cycle_cnt = 32'hFFFF_FFFE;
    m_preload = 1'b1;
    tick();
    check("preload", cycle_cnt, 32'hFFFF_FFFE);
    #2;
    release dut.r_cycle_cnt;
    m_preload = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      go = 1'b1;
      ticks(3);
      check("wrap_cnt", cycle_cnt, wrap_exp[i]);
      go = 1'b0;
      ticks(3);
    end

    ticks(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
